// File: rtl/rv_iccm_pkg.sv
// Shared types and constants for the ICCM controller and its storage array.
package rv_iccm_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } iccm_state_e;

    localparam int unsigned ICCM_DEFAULT_DEPTH = 256;
    localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0013;

endpackage

// File: rtl/rv_iccm_mem.sv
// DEPTH x 32 storage: one synchronous write port, one registered read port.
// The read port can substitute a NOP word so erroneous fetches stay fully registered.
module rv_iccm_mem
    import rv_iccm_pkg::*;
#(
    parameter int unsigned DEPTH     = ICCM_DEFAULT_DEPTH,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic             rd_nop,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= rd_nop ? NOP_INSTR : mem[raddr];
        end
    end

endmodule

// File: rtl/rv_iccm_ctrl.sv
// ICCM controller: core fetch port, streaming program load port, core reset hold.
// Optional `RV_ICCM_LD_CSUM_EN adds ld_csum_o, a modular sum of words in the current load.
module rv_iccm_ctrl
    import rv_iccm_pkg::*;
#(
    parameter int unsigned DEPTH     = ICCM_DEFAULT_DEPTH,
    parameter int unsigned AW        = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             core_rst_no,
    input  logic             fetch_req_i,
    input  logic [AW-1:0]    fetch_addr_i,
    output logic             fetch_valid_o,
    output logic [31:0]      fetch_rdata_o,
    output logic             fetch_err_o,
    input  logic             ld_start_i,
    input  logic [AW-1:0]    ld_base_i,
    input  logic [IDX_W:0]   ld_len_i,
    input  logic             ld_valid_i,
    input  logic [31:0]      ld_data_i,
    output logic             ld_ready_o,
    output logic             ld_busy_o,
    output logic             ld_done_o
`ifdef RV_ICCM_LD_CSUM_EN
    ,
    output logic [31:0]      ld_csum_o
`endif
);

    localparam logic [IDX_W:0] DEPTH_L   = (IDX_W + 1)'(DEPTH);
    localparam logic [AW:0]    LIMIT_B   = (AW + 1)'(DEPTH * 4);

    iccm_state_e      state_q, state_d;
    logic [IDX_W-1:0] base_q;
    logic [IDX_W:0]   len_q;
    logic [IDX_W:0]   cnt_q;
    logic             start_c;
    logic             hs_c;
    logic             last_c;
    logic             accept_c;
    logic             addr_err_c;
    logic             unused_c;

    assign unused_c   = ^{ld_base_i[AW-1:IDX_W+2], ld_base_i[1:0]};
    assign start_c    = (state_q == RUN) && ld_start_i;
    assign hs_c       = (state_q == LOAD) && ld_valid_i;
    assign last_c     = (cnt_q == (len_q - (IDX_W + 1)'(1)));
    // A load start in the same cycle wins over a fetch.
    assign accept_c   = (state_q == RUN) && fetch_req_i && !ld_start_i;
    assign addr_err_c = (fetch_addr_i[1:0] != 2'b00) || ({1'b0, fetch_addr_i} >= LIMIT_B);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (ld_start_i) begin
                    state_d = (ld_len_i == '0) ? RELEASE : LOAD;
                end
            end
            LOAD: begin
                if (hs_c && last_c) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            base_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            core_rst_no   <= 1'b0;
            ld_ready_o    <= 1'b0;
            ld_busy_o     <= 1'b0;
            ld_done_o     <= 1'b0;
            fetch_valid_o <= 1'b0;
            fetch_err_o   <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_rst_no   <= (state_d == RUN);
            ld_ready_o    <= (state_d == LOAD);
            ld_busy_o     <= (state_d != RUN);
            ld_done_o     <= (state_d == RELEASE);
            fetch_valid_o <= accept_c;
            fetch_err_o   <= accept_c && addr_err_c;
            if (start_c) begin
                base_q <= ld_base_i[IDX_W+1:2];
                len_q  <= (ld_len_i > DEPTH_L) ? DEPTH_L : ld_len_i;
                cnt_q  <= '0;
            end else if (hs_c) begin
                cnt_q  <= cnt_q + (IDX_W + 1)'(1);
            end
        end
    end

`ifdef RV_ICCM_LD_CSUM_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_csum_o <= 32'h0;
        end else if (start_c) begin
            ld_csum_o <= 32'h0;
        end else if (hs_c) begin
            ld_csum_o <= ld_csum_o + ld_data_i;
        end
    end
`endif

    rv_iccm_mem #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_mem (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .we     (hs_c),
        .waddr  (base_q + cnt_q[IDX_W-1:0]),
        .wdata  (ld_data_i),
        .re     (accept_c),
        .rd_nop (addr_err_c),
        .raddr  (fetch_addr_i[IDX_W+1:2]),
        .rdata  (fetch_rdata_o)
    );

endmodule

// File: tb/tb_rv_iccm_ctrl.sv
// Self-checking bench for rv_iccm_ctrl (DEPTH=256, AW=32) against an array model of the ICCM.
module tb_rv_iccm_ctrl;

    logic        clk;
    logic        rst_n;
    logic        core_rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        ld_start;
    logic [31:0] ld_base;
    logic [8:0]  ld_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_done;
`ifdef RV_ICCM_LD_CSUM_EN
    logic [31:0] ld_csum;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] ref_mem [256];
    bit          known   [256];
    logic [31:0] fixed_q [$];
    logic [31:0] ref_sum = 32'h0;

    rv_iccm_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_rst_no   (core_rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_valid_o (fetch_valid),
        .fetch_rdata_o (fetch_rdata),
        .fetch_err_o   (fetch_err),
        .ld_start_i    (ld_start),
        .ld_base_i     (ld_base),
        .ld_len_i      (ld_len),
        .ld_valid_i    (ld_valid),
        .ld_data_i     (ld_data),
        .ld_ready_o    (ld_ready),
        .ld_busy_o     (ld_busy),
        .ld_done_o     (ld_done)
`ifdef RV_ICCM_LD_CSUM_EN
        ,
        .ld_csum_o     (ld_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 9);
        logic [31:0] a;
        if (sel == 0)      a = $urandom();
        else if (sel == 1) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (sel == 2) a = 32'h400 + {$urandom_range(0, 1000), 2'b00};
        else               a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        return a;
    endfunction

    // Expected response for a fetch accepted at the previous edge.
    task automatic check_resp(input logic [31:0] addr);
        bit          e_err = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
        logic [7:0]  idx   = addr[9:2];
        chk("fetch_valid", 32'(fetch_valid), 32'd1);
        chk("fetch_err", 32'(fetch_err), 32'(e_err));
        if (e_err) chk("fetch_nop", fetch_rdata, 32'h0000_0013);
        else if (known[idx]) chk("fetch_rdata", fetch_rdata, ref_mem[idx]);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check_resp(addr);
    endtask

    task automatic fetch_burst(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a          = rand_addr();
            fetch_req  = 1'b1;
            fetch_addr = a;
            tick();
            check_resp(a);
        end
        fetch_req = 1'b0;
        tick();
        chk("fetch_idle", 32'(fetch_valid), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] base, input int unsigned len,
                           input bit gaps, input bit with_fetch);
        int unsigned eff  = (len > 256) ? 256 : len;
        logic [7:0]  bidx = base[9:2];
        logic [31:0] d;
        ld_start   = 1'b1;
        ld_base    = base;
        ld_len     = 9'(len);
        fetch_req  = with_fetch;
        fetch_addr = 32'h0;
        tick();
        ld_start   = 1'b0;
        fetch_req  = 1'b0;
        ref_sum    = 32'h0;
        chk("start_fetch_drop", 32'(fetch_valid), 32'd0);
        chk("start_core_rst", 32'(core_rst_n), 32'd0);
        chk("start_busy", 32'(ld_busy), 32'd1);
        chk("start_ready", 32'(ld_ready), 32'(eff != 0));
        chk("start_done", 32'(ld_done), 32'(eff == 0));
        for (int i = 0; i < int'(eff); i++) begin
            if (gaps) begin
                ld_valid   = 1'b0;
                fetch_req  = 1'b1;
                ld_start   = 1'b1;
                ld_base    = $urandom();
                tick();
                fetch_req  = 1'b0;
                ld_start   = 1'b0;
                chk("gap_no_fetch", 32'(fetch_valid), 32'd0);
                chk("gap_ready", 32'(ld_ready), 32'd1);
                chk("gap_core_rst", 32'(core_rst_n), 32'd0);
            end
            d        = (fixed_q.size() != 0) ? fixed_q.pop_front() : $urandom();
            ld_valid = 1'b1;
            ld_data  = d;
            tick();
            ld_valid = 1'b0;
            ref_mem[8'(bidx + 8'(i))] = d;
            known[8'(bidx + 8'(i))]   = 1'b1;
            ref_sum += d;
            chk("ld_ready", 32'(ld_ready), 32'(i != int'(eff) - 1));
            chk("ld_done", 32'(ld_done), 32'(i == int'(eff) - 1));
            chk("ld_core_rst", 32'(core_rst_n), 32'd0);
        end
        tick();
        chk("rel_done_clr", 32'(ld_done), 32'd0);
        chk("rel_core_rst", 32'(core_rst_n), 32'd1);
        chk("rel_busy", 32'(ld_busy), 32'd0);
        chk("rel_ready", 32'(ld_ready), 32'd0);
`ifdef RV_ICCM_LD_CSUM_EN
        chk("ld_csum", ld_csum, ref_sum);
`endif
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0;
            known[i]   = 1'b0;
        end
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
        ld_start = 1'b0; ld_base = 32'h0; ld_len = 9'h0; ld_valid = 1'b0; ld_data = 32'h0;

        tick(); tick();
        chk("rst_core_rst", 32'(core_rst_n), 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_rdata", fetch_rdata, 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_busy", 32'(ld_busy), 32'd0);
        chk("rst_ld_done", 32'(ld_done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_pre_edge", 32'(core_rst_n), 32'd0);
        tick();
        chk("rel_first_edge", 32'(core_rst_n), 32'd1);

        do_fetch(32'h0);
        tick();
        chk("no_req_valid", 32'(fetch_valid), 32'd0);

        do_load(32'h10, 3, 1'b1, 1'b0);
        do_fetch(32'h10); do_fetch(32'h14); do_fetch(32'h18);

        fixed_q.push_back(32'hDDDD_0001); fixed_q.push_back(32'hEEEE_0002);
        do_load(32'h3FC, 2, 1'b0, 1'b0);
        do_fetch(32'h3FC); do_fetch(32'h0);

        do_fetch(32'h2);
        do_fetch(32'h400);
        do_fetch(32'hFFFF_FFFC);

        do_load(32'h10, 0, 1'b0, 1'b0);
        do_fetch(32'h10); do_fetch(32'h14);

        do_load(32'h80 | 32'($urandom_range(0, 3)), 2, 1'b0, 1'b1);
        do_fetch(32'h80); do_fetch(32'h84);

        for (int k = 0; k < 6; k++) begin
            do_load($urandom(), $urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fetch_burst(12);
        end

        do_load(32'h200, 300, 1'b0, 1'b0);
        fetch_burst(24);

        fixed_q.push_back(32'hFFFF_FFFF); fixed_q.push_back(32'h0000_0002);
        do_load(32'h100, 2, 1'b0, 1'b0);
`ifdef RV_ICCM_LD_CSUM_EN
        chk("csum_wrap", ld_csum, 32'h0000_0001);
`endif

        // Abort a 4-word load after the first word via reset.
        ld_start = 1'b1; ld_base = 32'h40; ld_len = 9'd4;
        tick();
        ld_start = 1'b0;
        w = $urandom();
        ld_valid = 1'b1; ld_data = w;
        tick();
        ld_valid = 1'b0;
        ref_mem[16] = w; known[16] = 1'b1;
        chk("midload_busy", 32'(ld_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_core_rst", 32'(core_rst_n), 32'd0);
        chk("abort_busy", 32'(ld_busy), 32'd0);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        chk("abort_done", 32'(ld_done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_release", 32'(core_rst_n), 32'd1);
        chk("abort_no_done", 32'(ld_done), 32'd0);
`ifdef RV_ICCM_LD_CSUM_EN
        chk("abort_csum", ld_csum, 32'h0);
`endif
        do_fetch(32'h40);
        fetch_burst(16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_iccm_ctrl.md
Name: rv_iccm_ctrl

Overview:
- Parametrised instruction closely-coupled memory (ICCM) with a fetch port for the core and a streaming load port for program images.
- Replaces the fixed 256-word DFFRAM plus $readmemh preload: programs are written at run time through the load port.
- Holds the core in reset (core_rst_no) while a load is in progress, then releases it.
- Sits between rv_top's fetch interface and the SoC/bench program source.

Parameters:
DEPTH, 256, number of 32-bit words (power of two, >= 4); IDX_W = $clog2(DEPTH)
AW, 32, width of fetch and load byte addresses
NOP_INSTR, 32'h0000_0013, data returned on an erroneous fetch

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
core_rst_no  out  1  active-low reset to core; low while in reset, LOAD or RELEASE
fetch_req_i  in  1  fetch request, sampled in RUN only
fetch_addr_i  in  AW  fetch byte address
fetch_valid_o  out  1  read data valid, one cycle after an accepted request
fetch_rdata_o  out  32  instruction word
fetch_err_o  out  1  accompanies fetch_valid_o: misaligned or out-of-range
ld_start_i  in  1  start a load, sampled in RUN only
ld_base_i  in  AW  load base byte address, captured on start
ld_len_i  in  IDX_W+1  number of words to load, captured on start
ld_valid_i  in  1  load word valid
ld_data_i  in  32  load word
ld_ready_o  out  1  high in LOAD only
ld_busy_o  out  1  high in LOAD and RELEASE
ld_done_o  out  1  one-cycle pulse in RELEASE

Behaviour:
- Reset values: core_rst_no=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_err_o=0, ld_ready_o=0, ld_busy_o=0, ld_done_o=0; state=RUN; word counter=0. Memory contents are not reset.
- core_rst_no is registered:
  - it goes to 1 on the first clock edge after rst_ni deasserts;
  - it falls on the edge that enters LOAD;
  - it rises on the edge that leaves RELEASE.
- FSM states: RUN, LOAD, RELEASE.
- RUN -> LOAD on ld_start_i.
  - Captures base index = ld_base_i[IDX_W+1:2] and len; clears the counter.
  - If ld_len_i==0, goes to RELEASE instead.
  - ld_base_i[1:0] is ignored.
- LOAD behaviour:
  - ld_ready_o=1.
  - Each handshake (ld_valid_i & ld_ready_o) writes mem[(base+cnt) mod DEPTH] = ld_data_i and increments cnt. Writes past the top of memory wrap to index 0.
  - The handshake with cnt==len-1 moves to RELEASE; ld_ready_o is low from the next cycle.
  - ld_len_i > DEPTH is saturated to DEPTH.
- RELEASE behaviour: lasts one cycle with ld_done_o=1, then returns to RUN.
- Fetch behaviour:
  - Latency is 1: a request accepted in RUN at edge N gives fetch_valid_o=1 plus data/err in the cycle after N.
  - Err is set if fetch_addr_i[1:0]!=0 or fetch_addr_i >= DEPTH*4. In that case rdata=NOP_INSTR.
  - Otherwise rdata=mem[fetch_addr_i[IDX_W+1:2]].
  - fetch_valid_o is 0 in cycles with no accepted request. Back-to-back requests get back-to-back responses.
- Simultaneous events:
  - ld_start_i and fetch_req_i in the same RUN cycle: the load wins and the fetch is dropped (fetch_valid_o=0 next cycle).
  - ld_start_i in LOAD or RELEASE: ignored.
  - fetch_req_i in LOAD or RELEASE: ignored, no response.
- Reset mid-load: rst_ni low aborts immediately; state=RUN. Words already written stay in memory, and there is no ld_done_o pulse.
- Write/read collision: cannot occur, because writes happen only in LOAD and reads only in RUN.

Optional Feature:
RV_ICCM_LD_CSUM_EN
- Defined:
  - Adds output ld_csum_o [31:0], a 32-bit modular sum of all words accepted in the current load.
  - It is cleared to 0 on the RUN->LOAD (or RUN->RELEASE) edge and updated on each handshake.
  - It holds its value after RELEASE until the next start. Reset value is 0.
- Undefined: the port and the accumulator do not exist.

Decomposition:
- rv_iccm_pkg contains:
  - iccm_state_e enum (RUN, LOAD, RELEASE);
  - the NOP_INSTR default constant;
  - the ICCM_DEFAULT_DEPTH constant.
- Sub-module rv_iccm_mem:
  - DEPTH x 32 array, one synchronous write port and one synchronous read port, registered read data;
  - instantiated once by rv_iccm_ctrl, which owns the FSM, counter, error check and core reset.

Test Plan:
- Reset release, no load: core_rst_no goes to 1 on the first edge after rst_ni rises. fetch 0x0 -> fetch_valid_o=1 the next cycle, fetch_err_o=0.
- Load with base 0x10, len 3, data A,B,C (ld_valid_i gapped by one idle cycle):
  - core_rst_no=0 throughout and ld_done_o pulses once;
  - the fetches that follow return 0x10->A, 0x14->B, 0x18->C, each one cycle after its request.
- Wrap: DEPTH=256, base 0x3FC, len 2, data D,E -> fetch 0x3FC=D and 0x0=E.
- Fetch errors: fetch 0x2 -> err=1, rdata=0x00000013. Fetch 0x400 with DEPTH=256 -> err=1.
- Boundaries:
  - ld_len_i=0 -> RELEASE the next cycle; ld_done_o pulses and memory is unchanged.
  - ld_start_i together with fetch_req_i -> no fetch_valid_o.
- Reset mid-load after 1 of 4 words -> core_rst_no=0 and ld_busy_o=0 immediately. After release, the first word is readable.
- With RV_ICCM_LD_CSUM_EN defined: load 0xFFFFFFFF, 0x2 -> ld_csum_o=0x00000001.
